// File: rtl/dram_access_unit_pkg.sv
// Shared types and constants for the data-memory access unit.
// Holds the FSM state encoding and the decoder's access-size and direction codes.
package dram_access_unit_pkg;

    typedef enum logic [2:0] {
        DauIdle,
        DauRead,
        DauWait,
        DauWrite,
        DauResp
    } dau_state_e;

    localparam logic [1:0] DRAM_EX_WORD = 2'b00;
    localparam logic [1:0] DRAM_EX_BYTE = 2'b01;
    localparam logic [1:0] DRAM_EX_HALF = 2'b10;

    localparam logic DRAM_WRITE = 1'b1;
    localparam logic DRAM_READ  = 1'b0;

endpackage

// File: rtl/dram_access_unit_if.sv
// Request/response handshake between the EX stage and the data-memory access unit.
// The master modport is the pipeline side; the slave modport is the unit.
interface dram_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        dram_we;
    logic [1:0]  ex_type;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        misalign;
    logic        stall;

    modport master (
        output req_valid, dram_we, ex_type, ld_unsigned, addr, wdata,
        input  req_ready, rsp_valid, rsp_rdata, misalign, stall
    );

    modport slave (
        input  req_valid, dram_we, ex_type, ld_unsigned, addr, wdata,
        output req_ready, rsp_valid, rsp_rdata, misalign, stall
    );
endinterface

// File: rtl/dram_lane_unit.sv
// Combinational lane logic: extracts and extends load lanes, merges sub-word store data,
// and flags misaligned halfword/word accesses.
module dram_lane_unit
    import dram_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  ex_type,
    input  logic        ld_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged,
    output logic        misaligned
);

    logic        is_word;
    logic        is_half;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // ex_type 2'b11 never comes from the decoder; it falls through to the byte path.
    assign is_word = (ex_type == DRAM_EX_WORD);
    assign is_half = (ex_type == DRAM_EX_HALF);

    always_comb begin
        lane_b   = word[{off, 3'b000} +: 8];
        lane_h   = off[1] ? word[31:16] : word[15:0];
        load_val = word;
        merged   = word;
        if (is_word) begin
            merged = wdata;
        end else if (is_half) begin
            load_val = {{16{lane_h[15] & ~ld_unsigned}}, lane_h};
            merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
        end else begin
            load_val = {{24{lane_b[7] & ~ld_unsigned}}, lane_b};
            merged[{off, 3'b000} +: 8] = wdata[7:0];
        end
    end

    assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));

endmodule

// File: rtl/dram_access_unit.sv
// Data-memory access unit: executes word, halfword and byte loads/stores against a
// 1-cycle-latency word RAM, using read-modify-write for sub-word stores.
module dram_access_unit
    import dram_access_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    dram_access_unit_if.slave   bus,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    dau_state_e        state_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        ex_q;
    logic              we_q;
    logic              uns_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merged_q;
    logic              mis_q;

    logic              idle;
    logic              accept;
    logic [1:0]        lane_off;
    logic [1:0]        lane_ex;
    logic [31:0]       lane_load;
    logic [31:0]       lane_merged;
    logic              lane_mis;

    assign idle   = (state_q == DauIdle);
    assign accept = idle & bus.req_valid;

    // In IDLE the lane unit sees the incoming request to judge alignment;
    // afterwards it works on the latched request and the returned RAM word.
    assign lane_off = idle ? bus.addr[1:0] : addr_q[1:0];
    assign lane_ex  = idle ? bus.ex_type   : ex_q;

    dram_lane_unit u_lane (
        .word        (mem_rdata),
        .off         (lane_off),
        .ex_type     (lane_ex),
        .ld_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_val    (lane_load),
        .merged      (lane_merged),
        .misaligned  (lane_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DauIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            ex_q     <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            rdata_q  <= '0;
            merged_q <= '0;
            mis_q    <= 1'b0;
        end else begin
            unique case (state_q)
                DauIdle: begin
                    if (accept) begin
                        addr_q  <= bus.addr[ADDR_W+1:0];
                        wdata_q <= bus.wdata;
                        ex_q    <= bus.ex_type;
                        we_q    <= bus.dram_we;
                        uns_q   <= bus.ld_unsigned;
                        mis_q   <= lane_mis;
                        if (lane_mis) begin
                            state_q <= DauResp;
                        end else if ((bus.dram_we == DRAM_WRITE) &&
                                     (bus.ex_type == DRAM_EX_WORD)) begin
                            state_q <= DauWrite;
                        end else begin
                            state_q <= DauRead;
                        end
                    end
                end
                DauRead: state_q <= DauWait;
                DauWait: begin
                    if (we_q == DRAM_WRITE) begin
                        merged_q <= lane_merged;
                        state_q  <= DauWrite;
                    end else begin
                        rdata_q  <= lane_load;
                        state_q  <= DauResp;
                    end
                end
                DauWrite: state_q <= DauResp;
                DauResp:  state_q <= DauIdle;
                default:  state_q <= DauIdle;
            endcase
        end
    end

    assign bus.req_ready = idle;
    assign bus.stall     = ~idle;
    assign bus.rsp_valid = (state_q == DauResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.misalign  = (state_q == DauResp) & mis_q;

    assign mem_en    = ~rst & ((state_q == DauRead) | (state_q == DauWrite));
    assign mem_we    = ~rst & (state_q == DauWrite);
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign mem_wdata = (ex_q == DRAM_EX_WORD) ? wdata_q : merged_q;

endmodule

// File: tb/tb_dram_access_unit.sv
// Self-checking bench for dram_access_unit: directed requests, scoreboarded responses,
// and per-request latency / RAM-strobe checks against a behavioural RAM.
module tb_dram_access_unit;
    import dram_access_unit_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_access_unit_if bus ();

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic [31:0]       ram [0:1023];
    logic              pre_en = 1'b0;

    dram_access_unit #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk) begin
        if (pre_en) ram[4] <= 32'hAABBCCDD;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } rsp_t;

    rsp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] last_load = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the unit completes an access.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(sb_q.size()), 32'd1);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_misalign", {31'd0, bus.misalign}, {31'd0, e.mis});
            end
        end
    end

    task automatic preload();
        @(negedge clk) pre_en = 1'b1;
        @(negedge clk) pre_en = 1'b0;
    endtask

    // Issue one request and watch cycles 1..lat+1 after the accepting edge.
    task automatic do_req(input string name, input logic we, input logic [1:0] ex,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input int lat, input int rd_cyc, input int wr_cyc,
                          input logic mis, input logic [31:0] exp_rd);
        rsp_t e;
        int   w, got_rsp, got_rd, got_wr, n_stall;
        if (!we && !mis) last_load = exp_rd;
        e.rdata = last_load;
        e.mis   = mis;
        sb_q.push_back(e);
        @(negedge clk);
        bus.dram_we = we; bus.ex_type = ex; bus.ld_unsigned = uns;
        bus.addr = a; bus.wdata = wd; bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        got_rsp = 0; got_rd = 0; got_wr = 0; n_stall = 0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (bus.rsp_valid && got_rsp == 0) got_rsp = c;
            if (mem_en) begin
                chk({name, "_mem_addr"}, 32'(mem_addr), 32'(a[ADDR_W+1:2]));
                if (mem_we) got_wr = (got_wr == 0) ? c : 99;
                else        got_rd = (got_rd == 0) ? c : 99;
            end
            if (c <= lat && bus.stall) n_stall++;
            if (c == lat + 1) chk({name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
        end
        chk({name, "_rsp_cycle"}, 32'(got_rsp), 32'(lat));
        chk({name, "_read_cycle"}, 32'(got_rd), 32'(rd_cyc));
        chk({name, "_write_cycle"}, 32'(got_wr), 32'(wr_cyc));
        chk({name, "_stall_cycles"}, 32'(n_stall), 32'(lat));
    endtask

    initial begin
        int   cnt;
        logic we_seen;
        rsp_t e;

        bus.req_valid = 1'b0; bus.dram_we = 1'b0; bus.ex_type = 2'b00;
        bus.ld_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset state, with word 4 preloaded while in reset.
        pre_en = 1'b1;
        repeat (3) @(negedge clk);
        pre_en = 1'b0;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        rst = 1'b0;

        // 1. sb 0x11: read-modify-write of byte lane 1.
        do_req("sb_0x11", 1'b1, DRAM_EX_BYTE, 1'b0, 32'h11, 32'h55, 4, 1, 3, 1'b0, '0);
        chk("sb_ram", ram[4], 32'hAABB55DD);
        preload();

        // 2. Sub-word loads, address wrap, and ex_type 11 treated as byte.
        do_req("lh_0x12", 1'b0, DRAM_EX_HALF, 1'b0, 32'h12, '0, 3, 1, 0, 1'b0, 32'hFFFFAABB);
        do_req("lhu_0x12", 1'b0, DRAM_EX_HALF, 1'b1, 32'h12, '0, 3, 1, 0, 1'b0, 32'h0000AABB);
        do_req("lb_0x13", 1'b0, DRAM_EX_BYTE, 1'b0, 32'h13, '0, 3, 1, 0, 1'b0, 32'hFFFFFFAA);
        do_req("lbu_0x10", 1'b0, DRAM_EX_BYTE, 1'b1, 32'h10, '0, 3, 1, 0, 1'b0, 32'h000000DD);
        do_req("lhu_wrap", 1'b0, DRAM_EX_HALF, 1'b1, 32'h1010, '0, 3, 1, 0, 1'b0, 32'h0000CCDD);
        do_req("lb_ex11", 1'b0, 2'b11, 1'b0, 32'h11, '0, 3, 1, 0, 1'b0, 32'hFFFFFFCC);

        // 3. sw: single write, no read.
        do_req("sw_0x10", 1'b1, DRAM_EX_WORD, 1'b0, 32'h10, 32'h12345678, 2, 0, 1, 1'b0, '0);
        chk("sw_ram", ram[4], 32'h12345678);

        // 4. Misaligned halfword load: no RAM traffic, immediate response.
        do_req("lh_mis", 1'b0, DRAM_EX_HALF, 1'b0, 32'h11, '0, 1, 0, 0, 1'b1, '0);

        // 5. sh aborted by reset during WAIT.
        preload();
        @(negedge clk);
        bus.dram_we = 1'b1; bus.ex_type = DRAM_EX_HALF; bus.ld_unsigned = 1'b0;
        bus.addr = 32'h12; bus.wdata = 32'h9999; bus.req_valid = 1'b1;
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        we_seen = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        we_seen |= mem_we;
        @(negedge clk);
        we_seen |= mem_we;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_after_rst", {31'd0, bus.req_ready}, 32'd1);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            we_seen |= mem_we;
        end
        chk("abort_no_write", {31'd0, we_seen}, 32'd0);
        chk("abort_ram", ram[4], 32'hAABBCCDD);
        last_load = '0;

        // 6. req_valid held across lw then sb.
        preload();
        e.rdata = 32'hAABBCCDD; e.mis = 1'b0; sb_q.push_back(e);
        sb_q.push_back(e);
        @(negedge clk);
        bus.dram_we = 1'b0; bus.ex_type = DRAM_EX_WORD; bus.ld_unsigned = 1'b0;
        bus.addr = 32'h10; bus.wdata = '0; bus.req_valid = 1'b1;
        chk("held_first_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.dram_we = 1'b1; bus.ex_type = DRAM_EX_BYTE; bus.wdata = 32'h11;
        cnt = 1;
        while (!bus.req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("held_accept_gap", 32'(cnt), 32'd4);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("held_ram", ram[4], 32'hAABBCC11);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
